// File: rtl/toetsenbord_tx.sv
// PS/2 host-to-device command transmitter with a small status/interrupt slave port.
// The host inhibits the bus, then shifts start/data/parity/stop on device clock edges and checks the ACK.
module toetsenbord_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_cs_n,
    input  logic       s_write,
    input  logic [7:0] s_writedata,
    input  logic       s_read,
    output logic [7:0] s_readdata,
    output logic       irq,
    input  logic       kc,
    input  logic       kd,
    output logic       kc_oe,
    output logic       kd_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    n_q, n_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          kc_oe_q, kc_oe_d, kd_oe_q, kd_oe_d;
    logic          busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
    logic          timeout_q, timeout_d, dropped_q, dropped_d, irq_q, irq_d;
    logic          kc_m, kc_s, kc_d, kd_m, kd_s;
    logic          fall, wr, rd, abort;

    assign fall = kc_d & ~kc_s;
    assign wr   = ~s_cs_n & s_write;
    assign rd   = ~s_cs_n & s_read;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        n_d       = n_q;
        icnt_d    = icnt_q;
        tcnt_d    = tcnt_q;
        kc_oe_d   = kc_oe_q;
        kd_oe_d   = kd_oe_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;
        dropped_d = dropped_q;
        irq_d     = irq_q;
        abort     = 1'b0;

        // Read-clear is applied first so any flag set later in this cycle wins.
        if (rd) begin
            done_d    = 1'b0;
            ack_err_d = 1'b0;
            timeout_d = 1'b0;
            dropped_d = 1'b0;
            irq_d     = 1'b0;
        end

        case (state_q)
            IDLE: begin
                kc_oe_d = 1'b0;
                kd_oe_d = 1'b0;
                if (wr) begin
                    data_d    = s_writedata;
                    par_d     = ~^s_writedata;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    ack_err_d = 1'b0;
                    timeout_d = 1'b0;
                    dropped_d = 1'b0;
                    irq_d     = 1'b0;
                    icnt_d    = '0;
                    kc_oe_d   = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (icnt_q == I_LAST) begin
                    kc_oe_d = 1'b0;
                    kd_oe_d = 1'b1;
                    n_d     = '0;
                    tcnt_d  = '0;
                    state_d = SHIFT;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (fall) begin
                    tcnt_d = '0;
                    n_d    = n_q + 4'd1;
                    if (n_q < 4'd8) begin
                        kd_oe_d = ~data_q[n_q[2:0]];
                    end else if (n_q == 4'd8) begin
                        kd_oe_d = ~par_q;
                    end else begin
                        kd_oe_d = 1'b0;
                        state_d = ACK;
                    end
                end else if (tcnt_q == T_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ACK: begin
                if (fall) begin
                    tcnt_d = '0;
                    if (kd_s) ack_err_d = 1'b1;
                    state_d = WAIT_IDLE;
                end else if (tcnt_q == T_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (kc_s && kd_s) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    tcnt_d = '0;
                end else if (tcnt_q == T_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            kc_oe_d   = 1'b0;
            kd_oe_d   = 1'b0;
            timeout_d = 1'b1;
            busy_d    = 1'b0;
            irq_d     = 1'b1;
            state_d   = IDLE;
        end

        if (wr && state_q != IDLE) dropped_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            n_q       <= '0;
            icnt_q    <= '0;
            tcnt_q    <= '0;
            kc_oe_q   <= 1'b0;
            kd_oe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            dropped_q <= 1'b0;
            irq_q     <= 1'b0;
            kc_m      <= 1'b1;
            kc_s      <= 1'b1;
            kc_d      <= 1'b1;
            kd_m      <= 1'b1;
            kd_s      <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            n_q       <= n_d;
            icnt_q    <= icnt_d;
            tcnt_q    <= tcnt_d;
            kc_oe_q   <= kc_oe_d;
            kd_oe_q   <= kd_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
            dropped_q <= dropped_d;
            irq_q     <= irq_d;
            kc_m      <= kc;
            kc_s      <= kc_m;
            kc_d      <= kc_s;
            kd_m      <= kd;
            kd_s      <= kd_m;
        end
    end

    assign kc_oe      = kc_oe_q;
    assign kd_oe      = kd_oe_q;
    assign irq        = irq_q;
    assign s_readdata = {3'b000, dropped_q, timeout_q, ack_err_q, done_q, busy_q};

endmodule

// File: tb/tb_toetsenbord_tx.sv
// Directed bench for toetsenbord_tx: a PS/2 device model on open-drain lines,
// table-driven transfers plus timeout and mid-transfer reset sequences.
module tb_toetsenbord_tx;

    localparam int unsigned INH = 8;
    localparam int unsigned TMO = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_cs_n, s_write, s_read;
    logic [7:0] s_writedata;
    logic [7:0] s_readdata;
    logic       irq, kc_oe, kd_oe;
    logic       dev_kc, dev_kd;
    wire        kc, kd;

    int passed = 0;
    int total  = 0;

    // Open-drain bus: either side may pull a line low.
    assign kc = dev_kc & ~kc_oe;
    assign kd = dev_kd & ~kd_oe;

    always #5 clk = ~clk;

    toetsenbord_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .s_cs_n(s_cs_n), .s_write(s_write),
        .s_writedata(s_writedata), .s_read(s_read), .s_readdata(s_readdata),
        .irq(irq), .kc(kc), .kd(kd), .kc_oe(kc_oe), .kd_oe(kd_oe)
    );

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       ack_low;
        int         drop_at;
        logic       read_after;
        logic [7:0] exp_status;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_write(input logic [7:0] d);
        @(negedge clk);
        s_cs_n = 1'b0; s_write = 1'b1; s_writedata = d;
        @(negedge clk);
        s_cs_n = 1'b1; s_write = 1'b0;
    endtask

    task automatic do_read();
        @(negedge clk);
        s_cs_n = 1'b0; s_read = 1'b1;
        @(negedge clk);
        s_cs_n = 1'b1; s_read = 1'b0;
    endtask

    task automatic dev_edge(output logic b);
        dev_kc = 1'b0;
        repeat (10) @(negedge clk);
        b = kd;
        dev_kc = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic count_inhibit(input string name);
        int cnt = 0;
        while (kc_oe && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check(name, cnt, INH);
        repeat (5) @(negedge clk);
    endtask

    task automatic run_xfer(input vec_t v, input int idx);
        logic [10:0] frame;
        logic        b;
        do_write(v.data);
        check($sformatf("v%0d_busy_status", idx), s_readdata, 8'h01);
        check($sformatf("v%0d_busy_irq", idx), irq, 1'b0);
        count_inhibit($sformatf("v%0d_inhibit_len", idx));
        frame[0] = kd;
        for (int k = 1; k <= 10; k++) begin
            dev_edge(b);
            frame[k] = b;
            if (v.drop_at == k) do_write(8'h55);
        end
        dev_kd = v.ack_low ? 1'b0 : 1'b1;
        repeat (2) @(negedge clk);
        dev_edge(b);
        dev_kd = 1'b1;
        for (int c = 0; c < 200 && s_readdata[0]; c++) @(negedge clk);
        check($sformatf("v%0d_frame", idx), 32'(frame), 32'({1'b1, v.parity, v.data, 1'b0}));
        check($sformatf("v%0d_end_status", idx), s_readdata, v.exp_status);
        check($sformatf("v%0d_end_irq", idx), irq, 1'b1);
        if (v.read_after) begin
            do_read();
            check($sformatf("v%0d_clr_status", idx), s_readdata, 8'h00);
            check($sformatf("v%0d_clr_irq", idx), irq, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic b;
        int   cnt;

        // Vector 0 skips the read so vector 1's write must clear irq itself.
        vecs[0] = '{8'hED, 1'b1, 1'b1, 0, 1'b0, 8'h02};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h02};
        vecs[2] = '{8'hF4, 1'b0, 1'b0, 0, 1'b1, 8'h06};
        vecs[3] = '{8'hED, 1'b1, 1'b1, 3, 1'b1, 8'h12};

        reset = 1'b1; s_cs_n = 1'b1; s_write = 1'b0; s_read = 1'b0;
        s_writedata = '0; dev_kc = 1'b1; dev_kd = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_status", s_readdata, 8'h00);
        check("reset_lines", {30'd0, kc_oe, kd_oe, irq}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) run_xfer(vecs[i], i);

        // Device never clocks: lines must be released TMO cycles after the start bit.
        do_write(8'hFF);
        count_inhibit("tmo_inhibit_len");
        cnt = 5;
        while (kd_oe && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("tmo_len", cnt, TMO);
        check("tmo_status", s_readdata, 8'h08);
        check("tmo_irq", irq, 1'b1);
        check("tmo_lines", {kc_oe, kd_oe}, 2'b00);
        do_read();
        check("tmo_clr_status", s_readdata, 8'h00);

        // Reset after edge 5 of 0xAA, with a dropped write pending.
        do_write(8'hAA);
        count_inhibit("rst_inhibit_len");
        for (int k = 1; k <= 5; k++) begin
            dev_edge(b);
            if (k == 3) do_write(8'h55);
        end
        check("rst_pre_status", s_readdata, 8'h11);
        check("rst_pre_kd_oe", kd_oe, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_lines", {kc_oe, kd_oe}, 2'b00);
        check("rst_status", s_readdata, 8'h00);
        check("rst_irq", irq, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
